// File: rtl/data_mem_ctrl.sv
// Byte-addressable little-endian data memory for the MEM stage:
// req/done handshake, wait states, sized accesses, clear after reset, debug read.
module data_mem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_SIZE    = 256,
    parameter int ADDR_WIDTH  = $clog2(MEM_SIZE),
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_ready,
    output logic                  o_done,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_clear_busy,
    input  logic                  i_dbg_rd,
    input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
    output logic                  o_dbg_valid,
    output logic [DATA_WIDTH-1:0] o_dbg_data
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(LANES);
    localparam int WORDS = MEM_SIZE / LANES;
    localparam int WA    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state;
    logic [WA-1:0]           clr_cnt;
    logic [3:0]              wait_cnt;
    logic                    r_we;
    logic [1:0]              r_size;
    logic                    r_uns;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic [LANES-1:0][7:0]   mem [WORDS];

    logic                    in_idle;
    logic                    a_we;
    logic [1:0]              a_size;
    logic                    a_uns;
    logic [ADDR_WIDTH-1:0]   a_addr;
    logic [DATA_WIDTH-1:0]   a_wdata;
    int                      a_bytes;
    int                      a_off;
    logic                    a_err;
    logic [WA-1:0]           a_widx;
    logic [WA-1:0]           dbg_widx;
    logic [LANES-1:0]        be;
    logic [LANES-1:0][7:0]   wsh;
    logic [LANES-1:0][7:0]   rword;
    logic [LANES-1:0][7:0]   ld;
    logic                    msb;
    logic                    commit;

    // With zero wait states the access commits on the acceptance edge,
    // so the live request is used instead of the latched copy.
    always_comb begin
        in_idle  = (state == S_IDLE);
        a_we     = in_idle ? i_we       : r_we;
        a_size   = in_idle ? i_size     : r_size;
        a_uns    = in_idle ? i_unsigned : r_uns;
        a_addr   = in_idle ? i_addr     : r_addr;
        a_wdata  = in_idle ? i_wdata    : r_wdata;
        a_bytes  = 1 << a_size;
        a_off    = int'(a_addr) & (LANES - 1);
        a_err    = (int'(a_size) > LB) ||
                   ((int'(a_addr) & (a_bytes - 1)) != 0);
        a_widx   = WA'(a_addr >> LB);
        dbg_widx = WA'(i_dbg_addr >> LB);
        rword    = mem[a_widx];
        be       = '0;
        wsh      = '0;
        ld       = '0;
        msb      = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (k >= a_off && k < a_off + a_bytes) begin
                be[k] = 1'b1;
            end
            for (int j = 0; j < LANES; j++) begin
                if (j == k - a_off) begin
                    wsh[k] = a_wdata[8*j +: 8];
                end
                if (j == a_off + k) begin
                    ld[k] = rword[j];
                end
            end
        end
        for (int j = 0; j < LANES; j++) begin
            if (j == a_off + a_bytes - 1) begin
                msb = !a_uns && rword[j][7];
            end
        end
        for (int k = 0; k < LANES; k++) begin
            if (k >= a_bytes) begin
                ld[k] = {8{msb}};
            end
        end
        commit = !rst &&
                 ((state == S_WAIT && wait_cnt == 4'd1) ||
                  (in_idle && i_req && WAIT_CYCLES == 0));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (commit && a_we && !a_err) begin
                for (int k = 0; k < LANES; k++) begin
                    if (be[k]) begin
                        mem[a_widx][k] <= wsh[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_CLEAR;
            clr_cnt      <= '0;
            wait_cnt     <= '0;
            r_we         <= 1'b0;
            r_size       <= '0;
            r_uns        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            o_ready      <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_rdata      <= '0;
            o_clear_busy <= 1'b1;
            o_dbg_valid  <= 1'b0;
            o_dbg_data   <= '0;
        end else begin
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_dbg_valid <= 1'b0;
            if (i_dbg_rd && state != S_CLEAR) begin
                o_dbg_valid <= 1'b1;
                o_dbg_data  <= mem[dbg_widx];
            end
            if (commit) begin
                o_done <= 1'b1;
                o_err  <= a_err;
                if (a_err) begin
                    o_rdata <= '0;
                end else if (!a_we) begin
                    o_rdata <= ld;
                end
            end
            unique case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == WA'(WORDS - 1)) begin
                        state        <= S_IDLE;
                        o_ready      <= 1'b1;
                        o_clear_busy <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (i_req) begin
                        r_we    <= i_we;
                        r_size  <= i_size;
                        r_uns   <= i_unsigned;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        o_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    o_ready <= 1'b1;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl; three instances with WAIT_CYCLES 1, 0, 3.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req [3];
    logic        we [3];
    logic [1:0]  size [3];
    logic        uns [3];
    logic [7:0]  addr [3];
    logic [31:0] wdata [3];
    logic        ready [3];
    logic        done [3];
    logic        err [3];
    logic [31:0] rdata [3];
    logic        busy [3];
    logic        dbg_rd [3];
    logic [7:0]  dbg_addr [3];
    logic        dbg_valid [3];
    logic [31:0] dbg_data [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_ctrl #(
            .DATA_WIDTH (32),
            .MEM_SIZE   (256),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .i_req       (req[g]),
            .i_we        (we[g]),
            .i_size      (size[g]),
            .i_unsigned  (uns[g]),
            .i_addr      (addr[g]),
            .i_wdata     (wdata[g]),
            .o_ready     (ready[g]),
            .o_done      (done[g]),
            .o_err       (err[g]),
            .o_rdata     (rdata[g]),
            .o_clear_busy(busy[g]),
            .i_dbg_rd    (dbg_rd[g]),
            .i_dbg_addr  (dbg_addr[g]),
            .o_dbg_valid (dbg_valid[g]),
            .o_dbg_data  (dbg_data[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy[0] && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic access(input int d, input logic w, input logic [1:0] sz,
                          input logic un, input logic [7:0] a,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd, output logic e);
        check("ready_idle", 32'(ready[d]), 32'd1);
        req[d] = 1'b1; we[d] = w; size[d] = sz;
        uns[d] = un; addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            req[d] = 1'b0;
        end while (!done[d] && lat < 40);
        rd = rdata[d];
        e  = err[d];
        check("ready_in_done", 32'(ready[d]), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done[d]), 32'd0);
    endtask

    int          n;
    int          lat;
    logic [31:0] rd;
    logic        e;

    initial begin
        for (int i = 0; i < 3; i++) begin
            req[i] = 0; we[i] = 0; size[i] = 0; uns[i] = 0;
            addr[i] = 0; wdata[i] = 0; dbg_rd[i] = 0; dbg_addr[i] = 0;
        end
        @(negedge clk);
        check("rst_ready", 32'(ready[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_err", 32'(err[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_dbg_valid", 32'(dbg_valid[0]), 32'd0);
        check("rst_dbg_data", dbg_data[0], 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd1);
        rst = 1'b0;
        wait_clear(n);
        check("clear_cycles", 32'(n), 32'd64);
        check("ready_after_clear", 32'(ready[0]), 32'd1);

        dbg_rd[0] = 1'b1; dbg_addr[0] = 8'hFC;
        @(negedge clk);
        dbg_rd[0] = 1'b0;
        check("dbg_fc_valid", 32'(dbg_valid[0]), 32'd1);
        check("dbg_fc_data", dbg_data[0], 32'd0);

        access(0, 1, 2, 0, 8'h10, 32'h8899AABB, lat, rd, e);
        check("st_w_lat", 32'(lat), 32'd2);
        check("st_w_err", 32'(e), 32'd0);
        access(0, 0, 2, 0, 8'h10, 0, lat, rd, e);
        check("ld_w_10", rd, 32'h8899AABB);
        access(0, 0, 0, 0, 8'h13, 0, lat, rd, e);
        check("ld_b_13_s", rd, 32'hFFFFFF88);
        access(0, 0, 0, 1, 8'h13, 0, lat, rd, e);
        check("ld_b_13_u", rd, 32'h00000088);
        access(0, 0, 0, 1, 8'h12, 0, lat, rd, e);
        check("ld_b_12_u", rd, 32'h00000099);
        access(0, 0, 1, 0, 8'h10, 0, lat, rd, e);
        check("ld_h_10_s", rd, 32'hFFFFAABB);

        access(0, 1, 1, 0, 8'h22, 32'hDEAD1234, lat, rd, e);
        check("st_h_err", 32'(e), 32'd0);
        access(0, 0, 2, 0, 8'h20, 0, lat, rd, e);
        check("ld_w_20", rd, 32'h12340000);
        access(0, 0, 1, 0, 8'h22, 0, lat, rd, e);
        check("ld_h_22_s", rd, 32'h00001234);

        access(0, 1, 1, 0, 8'h21, 32'h0000FFFF, lat, rd, e);
        check("mis_err", 32'(e), 32'd1);
        check("mis_rdata", rd, 32'd0);
        check("mis_lat", 32'(lat), 32'd2);
        access(0, 0, 2, 0, 8'h20, 0, lat, rd, e);
        check("mis_no_write", rd, 32'h12340000);
        access(0, 0, 3, 0, 8'h18, 0, lat, rd, e);
        check("size3_err", 32'(e), 32'd1);
        check("size3_rdata", rd, 32'd0);

        req[0] = 1; we[0] = 1; size[0] = 2; addr[0] = 8'h10;
        wdata[0] = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        req[0] = 0; dbg_rd[0] = 1; dbg_addr[0] = 8'h13;
        check("col_wait_done", 32'(done[0]), 32'd0);
        @(negedge clk);
        check("col_done", 32'(done[0]), 32'd1);
        check("col_dbg_valid", 32'(dbg_valid[0]), 32'd1);
        check("col_dbg_old", dbg_data[0], 32'h8899AABB);
        @(negedge clk);
        dbg_rd[0] = 0;
        check("col_dbg_new", dbg_data[0], 32'h11223344);
        @(negedge clk);
        check("col_dbg_off", 32'(dbg_valid[0]), 32'd0);

        req[1] = 1; we[1] = 1; size[1] = 2; addr[1] = 8'h10;
        wdata[1] = 32'h55667788; dbg_rd[1] = 1; dbg_addr[1] = 8'h10;
        @(negedge clk);
        req[1] = 0; dbg_rd[1] = 0;
        check("w0_done_lat1", 32'(done[1]), 32'd1);
        check("w0_dbg_old", dbg_data[1], 32'd0);
        @(negedge clk);
        access(1, 0, 2, 0, 8'h10, 0, lat, rd, e);
        check("w0_ld_lat", 32'(lat), 32'd1);
        check("w0_ld_data", rd, 32'h55667788);

        access(2, 1, 1, 0, 8'h30, 32'h0000BEEF, lat, rd, e);
        check("w3_st_lat", 32'(lat), 32'd4);
        access(2, 0, 1, 1, 8'h30, 0, lat, rd, e);
        check("w3_ld_lat", 32'(lat), 32'd4);
        check("w3_ld_data", rd, 32'h0000BEEF);

        req[0] = 1; we[0] = 1; size[0] = 2; addr[0] = 8'h40;
        wdata[0] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req[0] = 0; rst = 1;
        @(negedge clk);
        check("abort_done", 32'(done[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd1);
        check("abort_ready", 32'(ready[0]), 32'd0);
        rst = 0;
        wait_clear(n);
        check("reclear_cycles", 32'(n), 32'd64);
        access(0, 0, 2, 0, 8'h40, 0, lat, rd, e);
        check("abort_no_write", rd, 32'd0);
        access(0, 0, 2, 0, 8'h10, 0, lat, rd, e);
        check("reclear_10", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
